divider_seq: RTL and testbench
==============================

# divider_seq

Sequential restoring divider, the inverse of the team's shift-add multiplier. It divides an 8-bit dividend by an 8-bit divisor one quotient bit per clock and returns quotient and remainder with a start/ready handshake. It sits beside the multiplier in the arithmetic datapath. Division by zero is detected in a single cycle.

## Interface
- WIDTH, 8, operand/result width in bits; the counter width is the smallest width that holds WIDTH+1.
- clk  input  1  clock; all state updates on its rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  load the operands and begin; sampled on each rising edge.
- A  input  WIDTH  dividend.
- B  input  WIDTH  divisor.
- Quotient  output  WIDTH  quotient; valid while ready=1.
- Remainder  output  WIDTH  remainder; valid while ready=1.
- ready  output  1  high when idle and results are valid.
- done  output  1  one-cycle pulse when a result becomes valid.
- div_by_zero  output  1  set when the last accepted divisor was 0; cleared on the next start.

## Operation
- Reset (rst_n=0) values:
  - Quotient=0, Remainder=0.
  - ready=1, done=0, div_by_zero=0.
  - state=IDLE.
- States:
  - IDLE: ready=1.
  - RUN: ready=0; WIDTH iterations.
  - FIX: ready=0; one cycle, signed build only.
- start=1 at any edge, in any state (including mid-RUN):
  - Latch the divisor D=B.
  - Load the quotient shift register with A and clear the partial remainder R (WIDTH+1 bits).
  - Clear the counter and div_by_zero.
  - Go to RUN.
  - A start that interrupts a running division abandons it without a done pulse.
- B=0 at start:
  - Go directly to a one-cycle RUN that writes Quotient=all ones, Remainder=A, div_by_zero=1.
  - Then go to IDLE with done pulse.
- RUN iteration (B≠0), for each of WIDTH cycles:
  - trial = {R[WIDTH-1:0], Q[WIDTH-1]} − {1'b0, D}, computed at WIDTH+1 bits.
  - If trial MSB=0: R=trial and Q={Q[WIDTH-2:0],1}.
  - Otherwise: R={R[WIDTH-1:0],Q[WIDTH-1]} and Q={Q[WIDTH-2:0],0}.
  - The counter increments each cycle.
  - After iteration WIDTH, go to IDLE, or to FIX in the signed build.
- Quotient/Remainder:
  - Quotient is the Q register and Remainder is R[WIDTH-1:0].
  - Intermediate values are visible during RUN but are not valid until ready=1.
- start held high: the block re-loads on every edge and never completes.

## Timing
- Unsigned latency, start sampled at edge k:
  - ready=0 after edge k.
  - Result valid, ready=1 and done=1 after edge k+WIDTH (8 cycles at default).
  - done=0 after edge k+WIDTH+1.
- Signed latency: WIDTH+1 cycles.
- Divide-by-zero latency: 1 cycle.
- Results hold unchanged in IDLE until the next start.
- rst_n asserted mid-operation forces the reset values immediately, without waiting for a clock edge. Deassertion is followed by IDLE.

## Configuration
- DIVIDER_SIGNED_EN defined (two's-complement operation):
  - On start, A and B are replaced by their magnitudes, and the sign of A and the XOR of the two signs are registered.
  - The FIX state negates Quotient if the signs differ and negates Remainder if A was negative. Division truncates toward zero.
  - A/0 gives Quotient=all ones (−1) and Remainder=A.
  - Most-negative/−1 wraps: Quotient=0x80, Remainder=0.
- DIVIDER_SIGNED_EN undefined: unsigned only; no FIX state, no magnitude/negation logic.

## Test plan
- Reset, then start with A=100, B=7 -> after 8 cycles: Quotient=14, Remainder=2, done for one cycle, div_by_zero=0.
- A=255, B=1 -> Quotient=255, Remainder=0. A=3, B=200 -> Quotient=0, Remainder=3.
- A=5, B=0 -> after 1 cycle: ready=1, Quotient=0xFF, Remainder=5, div_by_zero=1. Then A=9, B=3 -> div_by_zero cleared, Quotient=3, Remainder=0.
- Start A=50, B=5; 3 cycles later start A=9, B=4 -> no done for the first division; 8 cycles after the second start: Quotient=2, Remainder=1.
- Assert rst_n low 4 cycles into a division -> all outputs at reset values before the next edge; ready=1 with no done pulse after deassertion.
- With DIVIDER_SIGNED_EN:
  - A=−7 (0xF9), B=2 -> after 9 cycles: Quotient=0xFD (−3), Remainder=0xFF (−1).
  - A=0x80, B=0xFF -> Quotient=0x80, Remainder=0.

Source files
------------

// File: rtl/divider_seq.sv
// divider_seq: sequential restoring divider, one quotient bit per clock.
// Start/ready handshake with a one-cycle done pulse; divide-by-zero is
// resolved in a single RUN cycle.
// Build option: DIVIDER_SIGNED_EN selects two's-complement operation
// (magnitude conversion on start plus a FIX cycle that restores signs).
//
// state | meaning
// IDLE  | ready=1, results valid and held
// RUN   | one iteration per cycle, WIDTH cycles (1 cycle for divisor 0)
// FIX   | signed build only: sign correction of quotient/remainder
module divider_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             ready,
  output logic             done,
  output logic             div_by_zero
);

  // Smallest width that holds WIDTH+1.
  localparam int CW = $clog2(WIDTH + 2);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
`ifdef DIVIDER_SIGNED_EN
  localparam logic [1:0] S_FIX  = 2'd2;
`endif

  localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  // Partial remainder. The trial difference is formed at WIDTH+1 bits, but
  // the kept remainder is always below the divisor, so its top bit is
  // always zero and is not stored.
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] a_orig;
  logic [WIDTH:0]   shifted, trial;

`ifdef DIVIDER_SIGNED_EN
  logic sgn_a_q, sgn_a_d;
  logic sgn_x_q, sgn_x_d;

  // Operand magnitudes; the most negative value maps onto itself, which is
  // the correct unsigned magnitude.
  always_comb begin
    a_mag  = A[WIDTH-1] ? (~A + ONE) : A;
    b_mag  = B[WIDTH-1] ? (~B + ONE) : B;
    // Divide-by-zero returns the original dividend, recovered from its magnitude.
    a_orig = sgn_a_q ? (~q_q + ONE) : q_q;
  end
`else
  // Unsigned build: operands pass straight through.
  always_comb begin
    a_mag  = A;
    b_mag  = B;
    a_orig = q_q;
  end
`endif

  // One restoring step: shift in the next dividend bit, try subtracting D.
  always_comb begin
    shifted = {r_q, q_q[WIDTH-1]};
    trial   = shifted - {1'b0, div_q};
  end

  // Next-state logic; start has priority over everything, in any state.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
`ifdef DIVIDER_SIGNED_EN
    sgn_a_d = sgn_a_q;
    sgn_x_d = sgn_x_q;
`endif
    if (start) begin
      div_d   = b_mag;
      q_d     = a_mag;
      r_d     = '0;
      cnt_d   = '0;
      dbz_d   = 1'b0;
      state_d = S_RUN;
`ifdef DIVIDER_SIGNED_EN
      sgn_a_d = A[WIDTH-1];
      sgn_x_d = A[WIDTH-1] ^ B[WIDTH-1];
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_RUN: begin
          if (div_q == '0) begin
            q_d     = '1;
            r_d     = a_orig;
            dbz_d   = 1'b1;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            if (!trial[WIDTH]) begin
              r_d = trial[WIDTH-1:0];
              q_d = {q_q[WIDTH-2:0], 1'b1};
            end else begin
              r_d = shifted[WIDTH-1:0];
              q_d = {q_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
`ifdef DIVIDER_SIGNED_EN
              state_d = S_FIX;
`else
              done_d  = 1'b1;
              state_d = S_IDLE;
`endif
            end
          end
        end
`ifdef DIVIDER_SIGNED_EN
        S_FIX: begin
          if (sgn_x_q) q_d = ~q_q + ONE;
          if (sgn_a_q) r_d = ~r_q + ONE;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
`endif
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      r_q     <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

`ifdef DIVIDER_SIGNED_EN
  // Operand sign flags captured on start for the FIX cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgn_a_q <= 1'b0;
      sgn_x_q <= 1'b0;
    end else begin
      sgn_a_q <= sgn_a_d;
      sgn_x_q <= sgn_x_d;
    end
  end
`endif

  assign Quotient    = q_q;
  assign Remainder   = r_q;
  assign ready       = (state_q == S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_seq.sv
// tb_divider_seq: directed, table-driven checks for divider_seq plus
// hand-written sequences for interrupt, held start and mid-run reset.
module tb_divider_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] A, B;
  logic [7:0] Quotient, Remainder;
  logic       ready, done, div_by_zero;

  int checks   = 0;
  int failures = 0;

`ifdef DIVIDER_SIGNED_EN
  localparam int LN = 9;
`else
  localparam int LN = 8;
`endif

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    int         lat;
  } vec_t;

  vec_t vt[8];

  divider_seq #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .A          (A),
    .B          (B),
    .Quotient   (Quotient),
    .Remainder  (Remainder),
    .ready      (ready),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    @(negedge clk);
    A = v.a; B = v.b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, {31'd0, ready}, 32'd0);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
    end
    check({tag, "_latency"}, lat, v.lat);
    check({tag, "_quot"}, {24'd0, Quotient}, {24'd0, v.q});
    check({tag, "_rem"}, {24'd0, Remainder}, {24'd0, v.r});
    check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, v.dbz});
    check({tag, "_ready"}, {31'd0, ready}, 32'd1);
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_hold"}, {16'd0, Quotient, Remainder}, {16'd0, v.q, v.r});
  endtask

  initial begin
    int bad;
    vec_t v;
`ifdef DIVIDER_SIGNED_EN
    vt[0] = '{8'hF9, 8'd2,   8'hFD, 8'hFF, 1'b0, LN}; // -7/2
    vt[1] = '{8'h80, 8'hFF,  8'h80, 8'h00, 1'b0, LN}; // -128/-1 wraps
    vt[2] = '{8'd100, 8'd7,  8'd14, 8'd2,  1'b0, LN};
    vt[3] = '{8'd7,  8'hFE,  8'hFD, 8'd1,  1'b0, LN}; // 7/-2
    vt[4] = '{8'hFB, 8'd0,   8'hFF, 8'hFB, 1'b1, 1};  // -5/0
    vt[5] = '{8'd9,  8'd3,   8'd3,  8'd0,  1'b0, LN};
    vt[6] = '{8'hEC, 8'hFB,  8'd4,  8'd0,  1'b0, LN}; // -20/-5
    vt[7] = '{8'hED, 8'd4,   8'hFC, 8'hFD, 1'b0, LN}; // -19/4
`else
    vt[0] = '{8'd100, 8'd7,   8'd14,  8'd2,  1'b0, LN};
    vt[1] = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0, LN};
    vt[2] = '{8'd3,   8'd200, 8'd0,   8'd3,  1'b0, LN};
    vt[3] = '{8'd5,   8'd0,   8'hFF,  8'd5,  1'b1, 1};
    vt[4] = '{8'd9,   8'd3,   8'd3,   8'd0,  1'b0, LN};
    vt[5] = '{8'd0,   8'd5,   8'd0,   8'd0,  1'b0, LN};
    vt[6] = '{8'd200, 8'd200, 8'd1,   8'd0,  1'b0, LN};
    vt[7] = '{8'd255, 8'd16,  8'd15,  8'd15, 1'b0, LN};
`endif

    rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
    #1;
    check("reset_quot", {24'd0, Quotient}, 32'd0);
    check("reset_rem", {24'd0, Remainder}, 32'd0);
    check("reset_flags", {29'd0, ready, done, div_by_zero}, 32'b100);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Interrupted division: no done for the first, second completes normally.
    @(negedge clk);
    A = 8'd50; B = 8'd5; start = 1'b1;
    bad = 0;
    @(negedge clk);
    start = 1'b0;
    if (done) bad++;
    repeat (2) begin
      @(negedge clk);
      if (done || ready) bad++;
    end
    check("intr_no_done", bad, 0);
    v = '{8'd9, 8'd4, 8'd2, 8'd1, 1'b0, LN};
    run_vec(v, "intr_second");

    // Start held high: reloads every edge, never completes.
    @(negedge clk);
    A = 8'd20; B = 8'd3; start = 1'b1;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || ready) bad++;
    end
    check("held_start_busy", bad, 0);
    v = '{8'd20, 8'd3, 8'd6, 8'd2, 1'b0, LN};
    run_vec(v, "after_held");

    // Asynchronous reset four cycles into a division.
    @(negedge clk);
    A = 8'd100; B = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_quot", {24'd0, Quotient}, 32'd0);
    check("midrst_rem", {24'd0, Remainder}, 32'd0);
    check("midrst_flags", {29'd0, ready, done, div_by_zero}, 32'b100);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || !ready) bad++;
    end
    check("midrst_idle", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
